hashmap_arbiter: RTL and testbench

- Shares one hashmap instance between NUM_CLIENTS independent requesters.
- Two arbitration channels:
  - Insert channel, back-pressured by hashmap busy.
  - Lookup/modify/delete channel, one issue per cycle.
- Each channel uses its own round-robin pointer.
- A fixed-latency tag pipeline routes each lookup result back to the client that issued it.
- Sits between client logic and the hashmap ports (insert, busy, ins_key, ins_value, lookup, key, modify, del, mod_value, valid, value).

---
 rtl/hashmap_arb_pkg.sv | 9 +
 rtl/hashmap_arbiter_rr.sv | 29 ++
 rtl/hashmap_arbiter.sv | 107 ++++++++++
 tb/tb_hashmap_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/hashmap_arb_pkg.sv
// hashmap_arb_pkg: shared widths and the lookup tag type for hashmap_arbiter
package hashmap_arb_pkg;
  localparam int MAX_CLIENTS = 8;
  localparam int CLIENT_ID_BITS = (MAX_CLIENTS > 1) ? $clog2(MAX_CLIENTS) : 1;
  typedef struct packed {
    logic vld;
    logic [CLIENT_ID_BITS-1:0] id;
  } tag_t;
endpackage

// File: rtl/hashmap_arbiter_rr.sv
// rr_arbiter: picks the first requester at or after ptr, modulo N
// ports: req/ptr/en in, gnt one-hot and gnt_idx out (zero when nothing granted)
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  always_comb begin
    int idx;
    logic found;
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k;
      if (en && !found && req[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/hashmap_arbiter.sv
// hashmap_arbiter: shares one hashmap between NUM_CLIENTS requesters on insert and lookup channels
// ports: cl_ins_* / cl_req_* client requests, cl_rsp_* responses, insert/busy/ins_*, lookup/key/modify/del/mod_value/valid/value to the hashmap
module hashmap_arbiter
  import hashmap_arb_pkg::*;
#(
  parameter int NUM_CLIENTS  = 4,
  parameter int NUM_KEY_BITS = 64,
  parameter int NUM_VAL_BITS = 64,
  parameter int LOOKUP_LAT   = 6
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_CLIENTS-1:0]                   cl_ins_valid,
  output logic [NUM_CLIENTS-1:0]                   cl_ins_ready,
  input  logic [NUM_CLIENTS-1:0][NUM_KEY_BITS-1:0] cl_ins_key,
  input  logic [NUM_CLIENTS-1:0][NUM_VAL_BITS-1:0] cl_ins_value,
  input  logic [NUM_CLIENTS-1:0]                   cl_req_valid,
  output logic [NUM_CLIENTS-1:0]                   cl_req_ready,
  input  logic [NUM_CLIENTS-1:0][NUM_KEY_BITS-1:0] cl_req_key,
  input  logic [NUM_CLIENTS-1:0]                   cl_req_modify,
  input  logic [NUM_CLIENTS-1:0]                   cl_req_del,
  input  logic [NUM_CLIENTS-1:0][NUM_VAL_BITS-1:0] cl_req_mod_value,
  output logic [NUM_CLIENTS-1:0]                   cl_rsp_done,
  output logic                                     cl_rsp_hit,
  output logic [NUM_VAL_BITS-1:0]                  cl_rsp_value,
  output logic                                     insert,
  input  logic                                     busy,
  output logic [NUM_KEY_BITS-1:0]                  ins_key,
  output logic [NUM_VAL_BITS-1:0]                  ins_value,
  output logic                                     lookup,
  output logic [NUM_KEY_BITS-1:0]                  key,
  output logic                                     modify,
  output logic                                     del,
  output logic [NUM_VAL_BITS-1:0]                  mod_value,
  input  logic                                     valid,
  input  logic [NUM_VAL_BITS-1:0]                  value
);
  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  logic [IW-1:0] ins_ptr, req_ptr, ins_idx, req_idx;
  logic [NUM_CLIENTS-1:0] ins_gnt, req_gnt;
  logic [CLIENT_ID_BITS-1:0] lk_id;
  tag_t tags [LOOKUP_LAT];
  tag_t last;
  // a registered insert blocks the next grant, leaving the hashmap a cycle to raise busy
  rr_arbiter #(.N(NUM_CLIENTS), .IW(IW)) u_ins_arb (
    .req(cl_ins_valid), .ptr(ins_ptr), .en(!busy && !insert), .gnt(ins_gnt), .gnt_idx(ins_idx)
  );
  rr_arbiter #(.N(NUM_CLIENTS), .IW(IW)) u_req_arb (
    .req(cl_req_valid), .ptr(req_ptr), .en(1'b1), .gnt(req_gnt), .gnt_idx(req_idx)
  );
  assign cl_ins_ready = ins_gnt;
  assign cl_req_ready = req_gnt;
  assign last = tags[LOOKUP_LAT-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insert    <= 1'b0;
      ins_key   <= '0;
      ins_value <= '0;
      ins_ptr   <= '0;
    end else begin
      insert <= |ins_gnt;
      if (|ins_gnt) begin
        ins_key   <= cl_ins_key[ins_idx];
        ins_value <= cl_ins_value[ins_idx];
        ins_ptr   <= (ins_idx == IW'(NUM_CLIENTS - 1)) ? '0 : ins_idx + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup    <= 1'b0;
      modify    <= 1'b0;
      del       <= 1'b0;
      key       <= '0;
      mod_value <= '0;
      req_ptr   <= '0;
      lk_id     <= '0;
    end else begin
      lookup <= |req_gnt;
      del    <= |req_gnt && cl_req_del[req_idx];
      modify <= |req_gnt && cl_req_modify[req_idx] && !cl_req_del[req_idx];
      if (|req_gnt) begin
        key       <= cl_req_key[req_idx];
        mod_value <= cl_req_mod_value[req_idx];
        lk_id     <= CLIENT_ID_BITS'(req_idx);
        req_ptr   <= (req_idx == IW'(NUM_CLIENTS - 1)) ? '0 : req_idx + 1'b1;
      end
    end
  end
  // the last tag stage lines up with the hashmap's valid/value sample point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LOOKUP_LAT; i++) tags[i] <= '0;
      cl_rsp_done  <= '0;
      cl_rsp_hit   <= 1'b0;
      cl_rsp_value <= '0;
    end else begin
      tags[0] <= '{vld: lookup, id: lk_id};
      for (int i = 1; i < LOOKUP_LAT; i++) tags[i] <= tags[i-1];
      cl_rsp_done <= last.vld ? NUM_CLIENTS'(1) << last.id : '0;
      if (last.vld) begin
        cl_rsp_hit   <= valid;
        cl_rsp_value <= value;
      end
    end
  end
endmodule

// File: tb/tb_hashmap_arbiter.sv
// tb_hashmap_arbiter: randomized check of hashmap_arbiter against a transaction-level model
module tb_hashmap_arbiter;
  localparam int N = 4;
  localparam int LAT = 6;
  localparam logic [63:0] XV = 64'hA5A5_0000_FFFF_1234;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] cl_ins_valid, cl_ins_ready, cl_req_valid, cl_req_ready;
  logic [N-1:0][63:0] cl_ins_key, cl_ins_value, cl_req_key, cl_req_mod_value;
  logic [N-1:0] cl_req_modify, cl_req_del, cl_rsp_done;
  logic cl_rsp_hit, insert, busy, lookup, modify, del, valid;
  logic [63:0] cl_rsp_value, ins_key, ins_value, key, mod_value, value;
  hashmap_arbiter #(.NUM_CLIENTS(N), .NUM_KEY_BITS(64), .NUM_VAL_BITS(64), .LOOKUP_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cl_ins_valid(cl_ins_valid), .cl_ins_ready(cl_ins_ready), .cl_ins_key(cl_ins_key), .cl_ins_value(cl_ins_value),
    .cl_req_valid(cl_req_valid), .cl_req_ready(cl_req_ready), .cl_req_key(cl_req_key),
    .cl_req_modify(cl_req_modify), .cl_req_del(cl_req_del), .cl_req_mod_value(cl_req_mod_value),
    .cl_rsp_done(cl_rsp_done), .cl_rsp_hit(cl_rsp_hit), .cl_rsp_value(cl_rsp_value),
    .insert(insert), .busy(busy), .ins_key(ins_key), .ins_value(ins_value),
    .lookup(lookup), .key(key), .modify(modify), .del(del), .mod_value(mod_value),
    .valid(valid), .value(value)
  );
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ins_ptr, req_ptr, busy_cnt;
  logic e_insert, e_lookup, e_mod, e_del, e_hit;
  logic [63:0] e_ins_key, e_ins_val, e_key, e_mv, e_val;
  typedef struct {int id; int due; logic hit; logic [63:0] val;} rsp_t;
  rsp_t rq[$];
  bit sv[64];
  bit sh[64];
  logic [63:0] sval[64];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] m = '0;
    if (i >= 0) m[i] = 1'b1;
    return m;
  endfunction
  task automatic model_reset();
    ins_ptr = 0; req_ptr = 0; busy_cnt = 0;
    e_insert = 0; e_lookup = 0; e_mod = 0; e_del = 0; e_hit = 0;
    e_ins_key = '0; e_ins_val = '0; e_key = '0; e_mv = '0; e_val = '0;
    rq.delete();
  endtask
  task automatic zero_inputs();
    cl_ins_valid = '0; cl_req_valid = '0; cl_ins_key = '0; cl_ins_value = '0;
    cl_req_key = '0; cl_req_mod_value = '0; cl_req_modify = '0; cl_req_del = '0;
    busy = 0; valid = 0; value = '0;
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_hm"}, {59'd0, insert, lookup, modify, del, cl_rsp_hit}, 64'd0);
    check({tag, "_keys"}, ins_key | ins_value | key | mod_value | cl_rsp_value, 64'd0);
    check({tag, "_done"}, 64'(cl_rsp_done), 64'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    zero_inputs();
    #1;
    check_all_zero("rst");
    model_reset();
    @(negedge clk);
    check_all_zero("rst_hold");
    rst_n = 1;
  endtask
  task automatic step(input int mode);
    int s, gi, gr;
    logic [N-1:0] e_done;
    @(negedge clk);
    cyc++;
    e_done = '0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      e_done[rq[0].id] = 1'b1;
      e_hit = rq[0].hit;
      e_val = rq[0].val;
      void'(rq.pop_front());
    end
    check("insert", 64'(insert), 64'(e_insert));
    check("ins_key", ins_key, e_ins_key);
    check("ins_value", ins_value, e_ins_val);
    check("lookup", 64'(lookup), 64'(e_lookup));
    check("key", key, e_key);
    check("mod_value", mod_value, e_mv);
    check("modify", 64'(modify), 64'(e_mod));
    check("del", 64'(del), 64'(e_del));
    check("rsp_done", 64'(cl_rsp_done), 64'(e_done));
    check("rsp_hit", 64'(cl_rsp_hit), 64'(e_hit));
    check("rsp_value", cl_rsp_value, e_val);
    // hashmap model: busy for a random stretch after each insert, lookup results after LAT cycles
    busy = busy_cnt > 0;
    if (busy_cnt > 0) busy_cnt--;
    if (e_insert) busy_cnt = $urandom_range(0, 5);
    s = cyc % 64;
    valid = sv[s] ? sh[s] : 1'($urandom);
    value = sv[s] ? sval[s] : {$urandom, $urandom};
    sv[s] = 0;
    if (e_lookup) begin
      s = (cyc + LAT) % 64;
      sv[s] = 1;
      sh[s] = e_key[0];
      sval[s] = e_key ^ XV;
    end
    for (int i = 0; i < N; i++) begin
      cl_ins_key[i] = {$urandom, $urandom};
      cl_ins_value[i] = {$urandom, $urandom};
      cl_req_key[i] = {$urandom, $urandom};
      cl_req_mod_value[i] = {$urandom, $urandom};
      cl_ins_valid[i] = mode == 1 ? 1'b1 : mode == 2 ? ($urandom_range(0, 7) == 0) : mode == 0 ? 1'($urandom) : 1'b0;
      cl_req_valid[i] = mode == 1 ? 1'b1 : mode == 2 ? ($urandom_range(0, 7) == 0) : mode == 0 ? 1'($urandom) : 1'b0;
    end
    cl_req_modify = N'($urandom);
    cl_req_del = N'($urandom);
    #1;
    gi = (!busy && !e_insert) ? pick(cl_ins_valid, ins_ptr) : -1;
    gr = pick(cl_req_valid, req_ptr);
    check("ins_ready", 64'(cl_ins_ready), 64'(onehot(gi)));
    check("req_ready", 64'(cl_req_ready), 64'(onehot(gr)));
    e_insert = gi >= 0;
    if (gi >= 0) begin
      e_ins_key = cl_ins_key[gi];
      e_ins_val = cl_ins_value[gi];
      ins_ptr = (gi + 1) % N;
    end
    e_lookup = gr >= 0;
    e_del = gr >= 0 && cl_req_del[gr];
    e_mod = gr >= 0 && cl_req_modify[gr] && !cl_req_del[gr];
    if (gr >= 0) begin
      e_key = cl_req_key[gr];
      e_mv = cl_req_mod_value[gr];
      req_ptr = (gr + 1) % N;
      rq.push_back('{gr, cyc + LAT + 2, cl_req_key[gr][0], cl_req_key[gr] ^ XV});
    end
  endtask
  initial begin
    zero_inputs();
    model_reset();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int m = 0; m < 4; m++)
        for (int c = 0; c < 60; c++) step(m);
      for (int c = 0; c < 3; c++) step(1);
      do_reset();
      for (int c = 0; c < LAT + 4; c++) step(3);
      for (int c = 0; c < 4; c++) step(1);
    end
    for (int c = 0; c < LAT + 4; c++) step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
